// File: rtl/data_memory_ws.sv
// -----------------------------------------------------------------------------
// data_memory_ws
//
// Purpose:
//   Byte-addressable 32-bit data memory with a programmable number of wait
//   states per access. It supports byte, halfword and word loads/stores,
//   little-endian lane mapping, and sign/zero extension on sub-word loads.
//   Misaligned or reserved-size requests are rejected with a Fault pulse.
//   Each accepted access runs IDLE -> WAIT (WAIT_STATES cycles) -> DONE -> IDLE.
//   With WAIT_STATES = 0 the WAIT state is skipped.
//
// Parameters:
//   ADDR_WIDTH   word-address bits; the depth is 2**ADDR_WIDTH words
//   WAIT_STATES  extra cycles added to every access, 0..15
//
// Ports:
//   clk       sole clock, rising edge
//   reset     synchronous, active-high reset (the memory array is not reset)
//   Load      read request, sampled in IDLE only
//   Store     write request, sampled in IDLE only; wins over Load
//   Size      00 byte, 01 halfword, 10 word, 11 reserved (always faults)
//   Unsigned  loads: 1 zero-extends, 0 sign-extends sub-word data
//   Address   byte address: [ADDR_WIDTH+1:2] word index, [1:0] byte offset
//   DataIn    store data, right-justified
//   DataOut   registered, extended load result; held until the next load
//   Ready     one-cycle completion pulse (the DONE cycle)
//   Busy      high from the cycle after acceptance through DONE
//   Fault     one-cycle pulse in the cycle after a rejected request
// -----------------------------------------------------------------------------
module data_memory_ws #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Load,
  input  logic                  Store,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  input  logic [ADDR_WIDTH+1:0] Address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Fault
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS_COUNT = 4'(WAIT_STATES);
  localparam bit         NO_WAIT  = (WAIT_STATES == 0);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // State and latched operands
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [3:0]            r_count;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [31:0]           r_wdata;
  logic                  r_is_store;

  logic [31:0]           r_data_out;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_fault;

  logic [31:0]           r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Request decode in IDLE
  // ---------------------------------------------------------------------------
  logic w_req;
  logic w_misaligned;

  assign w_req = Load | Store;

  // NOTE: every signal written in a combinational block gets a default first,
  // so that no path through the block leaves it unassigned and infers a latch.
  always_comb begin
    w_misaligned = 1'b1;
    case (Size)
      SZ_BYTE: w_misaligned = 1'b0;
      SZ_HALF: w_misaligned = Address[0];
      SZ_WORD: w_misaligned = |Address[1:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load path
  // With no wait states the load result is captured at the accepting edge,
  // before the operands are latched, so the live inputs are used in IDLE.
  // In every other state the latched operands are used.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH+1:0] w_sel_addr;
  logic [1:0]            w_sel_size;
  logic                  w_sel_unsigned;
  logic [ADDR_WIDTH-1:0] w_sel_idx;
  logic [1:0]            w_sel_off;
  logic [31:0]           w_rd_word;
  logic [7:0]            w_rd_byte;
  logic [15:0]           w_rd_half;
  logic [31:0]           w_load_value;

  assign w_sel_addr     = (r_state == S_IDLE) ? Address  : r_addr;
  assign w_sel_size     = (r_state == S_IDLE) ? Size     : r_size;
  assign w_sel_unsigned = (r_state == S_IDLE) ? Unsigned : r_unsigned;
  assign w_sel_idx      = w_sel_addr[ADDR_WIDTH+1:2];
  assign w_sel_off      = w_sel_addr[1:0];
  assign w_rd_word      = r_mem[w_sel_idx];

  always_comb begin
    w_rd_byte = w_rd_word[7:0];
    case (w_sel_off)
      2'd0: w_rd_byte = w_rd_word[7:0];
      2'd1: w_rd_byte = w_rd_word[15:8];
      2'd2: w_rd_byte = w_rd_word[23:16];
      2'd3: w_rd_byte = w_rd_word[31:24];
      default: w_rd_byte = w_rd_word[7:0];
    endcase
  end

  // Halfword offset 2 selects the upper half (little-endian).
  assign w_rd_half = w_sel_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    w_load_value = w_rd_word;
    case (w_sel_size)
      SZ_BYTE: w_load_value = {{24{~w_sel_unsigned & w_rd_byte[7]}}, w_rd_byte};
      SZ_HALF: w_load_value = {{16{~w_sel_unsigned & w_rd_half[15]}}, w_rd_half};
      default: w_load_value = w_rd_word;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store path: replicate the right-justified data onto every lane and let the
  // byte enables pick the lanes that are actually written.
  // ---------------------------------------------------------------------------
  logic [3:0]  w_be;
  logic [31:0] w_wr_data;

  always_comb begin
    w_be      = 4'b0000;
    w_wr_data = r_wdata;
    case (r_size)
      SZ_BYTE: begin
        w_be      = 4'b0001 << r_addr[1:0];
        w_wr_data = {4{r_wdata[7:0]}};
      end
      SZ_HALF: begin
        w_be      = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wr_data = {2{r_wdata[15:0]}};
      end
      SZ_WORD: begin
        w_be      = 4'b1111;
        w_wr_data = r_wdata;
      end
      default: begin
        w_be      = 4'b0000;
        w_wr_data = r_wdata;
      end
    endcase
  end

  // NOTE: the storage array has no reset branch; contents survive reset and
  // power up undefined, which also lets the array map onto RAM macros.
  // The store commits on the edge that ends DONE. A reset at that edge
  // aborts the access, so the write is suppressed.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_DONE) && r_is_store) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[r_addr[ADDR_WIDTH+1:2]][8*k +: 8] <= w_wr_data[8*k +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= 4'd0;
      r_addr     <= '0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_wdata    <= 32'd0;
      r_is_store <= 1'b0;
      r_data_out <= 32'd0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      // Ready and Fault are single-cycle pulses.
      r_ready <= 1'b0;
      r_fault <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_misaligned) begin
              // Rejected: no access, and the state stays IDLE.
              r_fault <= 1'b1;
            end else begin
              r_addr     <= Address;
              r_size     <= Size;
              r_unsigned <= Unsigned;
              r_wdata    <= DataIn;
              r_is_store <= Store;
              r_busy     <= 1'b1;
              if (NO_WAIT) begin
                r_state <= S_DONE;
                r_count <= 4'd0;
                r_ready <= 1'b1;
                if (!Store) begin
                  r_data_out <= w_load_value;
                end
              end else begin
                r_state <= S_WAIT;
                r_count <= WS_COUNT;
              end
            end
          end
        end

        S_WAIT: begin
          // The counter reaches zero on the same edge that enters DONE,
          // so WAIT lasts exactly WAIT_STATES cycles.
          if (r_count <= 4'd1) begin
            r_state <= S_DONE;
            r_count <= 4'd0;
            r_ready <= 1'b1;
            if (!r_is_store) begin
              r_data_out <= w_load_value;
            end
          end else begin
            r_count <= r_count - 4'd1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign DataOut = r_data_out;
  assign Ready   = r_ready;
  assign Busy    = r_busy;
  assign Fault   = r_fault;

endmodule

// File: tb/tb_data_memory_ws.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ws
//
// Directed bench for data_memory_ws. One instance uses WAIT_STATES=2 and
// ADDR_WIDTH=10. A second instance uses WAIT_STATES=0 and ADDR_WIDTH=4.
// Inputs are driven on the falling edge and outputs are sampled on the
// falling edge, half a cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_data_memory_ws;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // WAIT_STATES = 2 instance
  logic        ld, st, uns;
  logic [1:0]  sz;
  logic [11:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        rdy, bsy, flt;

  // WAIT_STATES = 0 instance
  logic        ld0, st0, uns0;
  logic [1:0]  sz0;
  logic [5:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;
  logic        rdy0, bsy0, flt0;

  int n_tests = 0;
  int n_fail  = 0;

  data_memory_ws #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .Load(ld), .Store(st), .Size(sz),
    .Unsigned(uns), .Address(addr), .DataIn(din), .DataOut(dout),
    .Ready(rdy), .Busy(bsy), .Fault(flt)
  );

  data_memory_ws #(.ADDR_WIDTH(4), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .Load(ld0), .Store(st0), .Size(sz0),
    .Unsigned(uns0), .Address(addr0), .DataIn(din0), .DataOut(dout0),
    .Ready(rdy0), .Busy(bsy0), .Fault(flt0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One full access on the WAIT_STATES=2 instance. Operand inputs are scrambled
  // right after acceptance to show that the latched copies are used.
  task automatic access(input string tag, input logic s, input logic l,
                        input logic [1:0] z, input logic u,
                        input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] exp_load);
    logic [31:0] prev;
    @(negedge clk);
    prev = dout;
    st = s; ld = l; sz = z; uns = u; addr = a; din = d;
    @(posedge clk);
    @(negedge clk);
    st = 1'b0; ld = 1'b0; sz = ~z; uns = ~u; addr = ~a; din = ~d;
    check($sformatf("%s c1 busy", tag), 32'(bsy), 32'd1);
    check($sformatf("%s c1 ready", tag), 32'(rdy), 32'd0);
    @(negedge clk);
    check($sformatf("%s c2 ready", tag), 32'(rdy), 32'd0);
    @(negedge clk);
    check($sformatf("%s c3 ready", tag), 32'(rdy), 32'd1);
    check($sformatf("%s c3 busy", tag), 32'(bsy), 32'd1);
    if (s) check($sformatf("%s dout kept", tag), dout, prev);
    else   check($sformatf("%s dout", tag), dout, exp_load);
    @(negedge clk);
    check($sformatf("%s c4 ready", tag), 32'(rdy), 32'd0);
    check($sformatf("%s c4 busy", tag), 32'(bsy), 32'd0);
  endtask

  // A request that must be rejected.
  task automatic fault_req(input string tag, input logic s, input logic l,
                           input logic [1:0] z, input logic [11:0] a);
    logic [31:0] prev;
    @(negedge clk);
    prev = dout;
    st = s; ld = l; sz = z; uns = 1'b0; addr = a; din = 32'h0;
    @(posedge clk);
    @(negedge clk);
    st = 1'b0; ld = 1'b0;
    check($sformatf("%s fault", tag), 32'(flt), 32'd1);
    check($sformatf("%s busy", tag), 32'(bsy), 32'd0);
    check($sformatf("%s ready", tag), 32'(rdy), 32'd0);
    @(negedge clk);
    check($sformatf("%s fault pulse", tag), 32'(flt), 32'd0);
    check($sformatf("%s dout kept", tag), dout, prev);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ld = 0; st = 0; uns = 0; sz = SZ_W; addr = '0; din = '0;
    ld0 = 0; st0 = 0; uns0 = 0; sz0 = SZ_W; addr0 = '0; din0 = '0;
    repeat (2) @(negedge clk);
    check("rst dout", dout, 32'h0);
    check("rst ready", 32'(rdy), 32'd0);
    check("rst busy", 32'(bsy), 32'd0);
    check("rst fault", 32'(flt), 32'd0);
    check("rst dout0", dout0, 32'h0);
    reset = 1'b0;

    // Basic word store/load and sub-word lanes
    access("sw010",  1, 0, SZ_W, 0, 12'h010, 32'hDEADBEEF, 32'h0);
    access("lw010",  0, 1, SZ_W, 0, 12'h010, 32'h0, 32'hDEADBEEF);
    access("sb011",  1, 0, SZ_B, 0, 12'h011, 32'hFFFFFF55, 32'h0);
    access("lw010b", 0, 1, SZ_W, 0, 12'h010, 32'h0, 32'hDEAD55EF);
    access("lb013",  0, 1, SZ_B, 0, 12'h013, 32'h0, 32'hFFFFFFDE);
    access("lbu013", 0, 1, SZ_B, 1, 12'h013, 32'h0, 32'h000000DE);
    access("lh012",  0, 1, SZ_H, 0, 12'h012, 32'h0, 32'hFFFFDEAD);
    access("lhu010", 0, 1, SZ_H, 1, 12'h010, 32'h0, 32'h000055EF);
    access("lb011",  0, 1, SZ_B, 0, 12'h011, 32'h0, 32'h00000055);
    access("sh012",  1, 0, SZ_H, 0, 12'h012, 32'hFFFF1234, 32'h0);
    access("lw010c", 0, 1, SZ_W, 0, 12'h010, 32'h0, 32'h123455EF);
    access("lhu012", 0, 1, SZ_H, 1, 12'h012, 32'h0, 32'h00001234);

    // Rejected requests leave memory and DataOut untouched
    fault_req("lw012 mis", 0, 1, SZ_W, 12'h012);
    fault_req("lh011 mis", 0, 1, SZ_H, 12'h011);
    fault_req("size11",    0, 1, SZ_R, 12'h010);
    fault_req("sw012 mis", 1, 0, SZ_W, 12'h012);
    fault_req("sh013 mis", 1, 0, SZ_H, 12'h013);
    access("lw010d", 0, 1, SZ_W, 0, 12'h010, 32'h0, 32'h123455EF);

    // Reset during WAIT aborts a pending store
    access("sw020", 1, 0, SZ_W, 0, 12'h020, 32'h0BADF00D, 32'h0);
    @(negedge clk);
    st = 1; sz = SZ_W; addr = 12'h020; din = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    st = 0;
    check("abort wait accepted", 32'(bsy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort wait ready", 32'(rdy), 32'd0);
    check("abort wait busy", 32'(bsy), 32'd0);
    check("abort wait dout", dout, 32'h0);
    check("abort wait fault", 32'(flt), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort wait no ready", 32'(rdy), 32'd0);
    access("lw020a", 0, 1, SZ_W, 0, 12'h020, 32'h0, 32'h0BADF00D);

    // Reset during DONE suppresses the commit
    @(negedge clk);
    st = 1; sz = SZ_W; addr = 12'h020; din = 32'hCAFEBABE;
    @(posedge clk);
    @(negedge clk);
    st = 0;
    @(negedge clk);
    @(negedge clk);
    check("abort done ready", 32'(rdy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort done busy", 32'(bsy), 32'd0);
    check("abort done dout", dout, 32'h0);
    reset = 1'b0;
    access("lw020b", 0, 1, SZ_W, 0, 12'h020, 32'h0, 32'h0BADF00D);

    // Reset wins over a request at the same edge
    @(negedge clk);
    reset = 1'b1; ld = 1; sz = SZ_W; addr = 12'h020;
    @(negedge clk);
    check("rst prio busy", 32'(bsy), 32'd0);
    check("rst prio ready", 32'(rdy), 32'd0);
    reset = 1'b0; ld = 0;

    // Store wins over Load
    access("ldst030", 1, 1, SZ_W, 0, 12'h030, 32'hA5A5A5A5, 32'h0);
    access("lw030",   0, 1, SZ_W, 0, 12'h030, 32'h0, 32'hA5A5A5A5);

    // Requests toggled while Busy are ignored; latched operands hold
    @(negedge clk);
    st = 1; sz = SZ_W; addr = 12'h040; din = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    addr = 12'h044; din = 32'hFFFFFFFF; st = 0; ld = 1;
    check("tog c1 busy", 32'(bsy), 32'd1);
    @(negedge clk);
    st = 1; ld = 0;
    check("tog c2 ready", 32'(rdy), 32'd0);
    @(negedge clk);
    check("tog c3 ready", 32'(rdy), 32'd1);
    st = 0; ld = 0;
    @(negedge clk);
    check("tog c4 busy", 32'(bsy), 32'd0);
    @(negedge clk);
    check("tog c5 busy", 32'(bsy), 32'd0);
    check("tog c5 ready", 32'(rdy), 32'd0);
    access("lw040", 0, 1, SZ_W, 0, 12'h040, 32'h0, 32'h11223344);

    // Top word of the array
    access("swffc", 1, 0, SZ_W, 0, 12'hFFC, 32'h89ABCDEF, 32'h0);
    access("lbfff", 0, 1, SZ_B, 0, 12'hFFF, 32'h0, 32'hFFFFFF89);
    access("lwffc", 0, 1, SZ_W, 0, 12'hFFC, 32'h0, 32'h89ABCDEF);

    // WAIT_STATES = 0: store, then a load held high
    @(negedge clk);
    st0 = 1; sz0 = SZ_W; addr0 = 6'h04; din0 = 32'h0000BEEF;
    @(posedge clk);
    @(negedge clk);
    st0 = 0;
    check("ws0 st ready", 32'(rdy0), 32'd1);
    check("ws0 st busy", 32'(bsy0), 32'd1);
    check("ws0 st dout", dout0, 32'h0);
    @(negedge clk);
    check("ws0 st idle ready", 32'(rdy0), 32'd0);
    check("ws0 st idle busy", 32'(bsy0), 32'd0);
    ld0 = 1; addr0 = 6'h04;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("ws0 held ready %0d", i), 32'(rdy0), 32'(i % 2));
      check($sformatf("ws0 held busy %0d", i), 32'(bsy0), 32'(i % 2));
      if (i == 1) check("ws0 held dout", dout0, 32'h0000BEEF);
    end
    ld0 = 0;
    @(negedge clk);
    check("ws0 released", 32'(rdy0), 32'd0);

    // WAIT_STATES = 0: Load toggled inside the DONE cycle
    ld0 = 1;
    @(negedge clk);
    check("ws0 tog ready", 32'(rdy0), 32'd1);
    ld0 = 0;
    #2 ld0 = 1;
    #2 ld0 = 0;
    @(negedge clk);
    check("ws0 tog c2 busy", 32'(bsy0), 32'd0);
    check("ws0 tog c2 ready", 32'(rdy0), 32'd0);
    @(negedge clk);
    check("ws0 tog c3 busy", 32'(bsy0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ws.md
DATA_MEMORY_WS -- requirements
Module: data_memory_ws

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address bits; depth = 2**ADDR_WIDTH 32-bit words.
REQ-002 Parameter WAIT_STATES, default 0, range 0..15; extra cycles added to every access.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Load  input  1  read request, sampled only in IDLE.
REQ-006 Store  input  1  write request, sampled only in IDLE; wins over Load when both are high.
REQ-007 Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 Unsigned  input  1  loads only: 1 zero-extends, 0 sign-extends sub-word data.
REQ-009 Address  input  ADDR_WIDTH+2  byte address; [ADDR_WIDTH+1:2] word index, [1:0] byte offset.
REQ-010 DataIn  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 DataOut  output  32  registered load result, extended to 32 bits.
REQ-012 Ready  output  1  one-cycle pulse marking access completion.
REQ-013 Busy  output  1  high while an accepted access is in flight.
REQ-014 Fault  output  1  one-cycle pulse for a rejected request.

Function
REQ-015 FSM states: IDLE, WAIT, DONE; only IDLE samples Load/Store.
REQ-016 Alignment: halfword requires Address[0]=0; word requires Address[1:0]=00; Size=11 always faults.
REQ-017 Faulting request in IDLE: Fault high next cycle for exactly one cycle, no memory access, state stays IDLE, DataOut unchanged.
REQ-018 Valid request in IDLE: latch Address, Size, Unsigned, DataIn, op; Busy high from next cycle; go to WAIT with counter=WAIT_STATES, or DONE directly when WAIT_STATES=0.
REQ-019 WAIT: decrement counter each cycle; go to DONE when counter reaches 0.
REQ-020 DONE: Ready=1, Busy=1 for one cycle, then IDLE; Ready rises exactly WAIT_STATES+1 cycles after the accepting edge.
REQ-021 Store commits at the edge ending the DONE cycle; only addressed byte lanes change, others keep prior contents.
REQ-022 Byte order little-endian: byte offset k maps to bits [8k+7:8k]; halfword offset 2 maps to [31:16].
REQ-023 Load: DataOut updated at the edge entering DONE with extracted, extended lane(s); holds value until next completed load.
REQ-024 Store completion leaves DataOut unchanged.
REQ-025 Load/Store changes while Busy are ignored; latched operands unaffected by input changes after acceptance.
REQ-026 Back-to-back: request held high through DONE is re-accepted in the IDLE cycle that follows; minimum spacing WAIT_STATES+2 cycles.
REQ-027 Load after Store to same word returns the stored data (write committed before next acceptance).
REQ-028 Address bits above ADDR_WIDTH+1 do not exist; index wraps naturally within depth.
REQ-029 Memory contents unaffected by reset and uninitialised at power-up.

Reset
REQ-030 reset high at an edge: state IDLE, counter 0, DataOut=0, Ready=0, Busy=0, Fault=0.
REQ-031 reset during WAIT or DONE aborts the access: a pending store is NOT written, no Ready pulse.
REQ-032 reset has priority over any request sampled at the same edge.

Verification (WAIT_STATES=2 unless noted)
REQ-033 SW 0xDEADBEEF to 0x010, then LW 0x010 -> Ready 3 cycles after each acceptance, DataOut=0xDEADBEEF, Busy high 3 cycles.
REQ-034 After REQ-033, SB 0x55 to 0x011, then LW 0x010 -> 0xDEAD55EF; LB 0x013 -> 0xFFFFFFDE; LBU 0x013 -> 0x000000DE; LH 0x012 -> 0xFFFFDEAD.
REQ-035 LW 0x012, LH 0x011, Size=11 -> Fault pulse 1 cycle each, no Ready, DataOut unchanged, memory unchanged.
REQ-036 SW 0x12345678 to 0x020, reset asserted in WAIT -> no Ready, outputs zero; LW 0x020 returns prior contents, not 0x12345678.
REQ-037 Load and Store both high, Address 0x030, DataIn 0xA5A5A5A5 -> store performed; subsequent LW returns 0xA5A5A5A5.
REQ-038 WAIT_STATES=0: Load held high continuously -> Ready pulses every 2nd cycle; toggling Load while Busy causes no extra accesses.
